// File: rtl/sisc_pkg.sv
// Shared definitions for the sisc instruction fetch path: opcode field,
// well-known opcodes, the fetch sequencer state encoding and decode helpers.
package sisc_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [31:0] NOP_WORD = {OP_NOP, 28'h0000000};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic is_halt(input logic [31:0] word);
    return opcode_of(word) == OP_HALT;
  endfunction

endpackage

// File: rtl/sisc_pc_reg.sv
// Program counter register: branch load has priority over increment, and the
// increment wraps naturally at the address width.
module sisc_pc_reg
  import sisc_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// Instruction fetch sequencer: issues one instruction-memory read per accepted
// fetch request, latches the IR, and tracks branches, halt and timeout faults.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              fetch_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              im_rd,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_data,
  input  logic              im_ack,
  output logic [31:0]       IR,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  fetch_state_t      state;
  fetch_state_t      state_nxt;

  logic [7:0]        wait_cnt;
  logic [7:0]        wait_cnt_inc;
  logic              br_pend;
  logic [ADDR_W-1:0] br_pend_addr;

  logic              start_fetch;
  logic              accept;
  logic              timeout;
  logic [ADDR_W-1:0] fetch_addr;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              pc_inc;

  assign wait_cnt_inc = wait_cnt + 8'd1;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A branch seen during WAIT, either earlier or alongside the ack, turns the
  // returning word into a discard and redirects the PC instead.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    accept      = 1'b0;
    timeout     = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = br_addr;
    pc_inc      = 1'b0;
    fetch_addr  = br_taken ? br_addr : pc;
    case (state)
      ST_IDLE: begin
        if (br_taken) begin
          pc_load = 1'b1;
        end
        if (fetch_req) begin
          start_fetch = 1'b1;
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (im_ack) begin
          if (br_taken || br_pend) begin
            pc_load     = 1'b1;
            pc_load_val = br_taken ? br_addr : br_pend_addr;
            state_nxt   = ST_IDLE;
          end else begin
            accept    = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = is_halt(im_data) ? ST_HALT : ST_IDLE;
          end
        end else if (wait_cnt_inc == MAX_WAIT_C) begin
          timeout   = 1'b1;
          state_nxt = ST_FAULT;
        end
      end
      default: begin
      end
    endcase
  end

  // Memory interface, IR latch, sticky status and the WAIT bookkeeping.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      im_rd        <= 1'b0;
      im_addr      <= '0;
      IR           <= NOP_WORD;
      ir_valid     <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      wait_cnt     <= '0;
      br_pend      <= 1'b0;
      br_pend_addr <= '0;
    end else begin
      ir_valid <= accept;
      if (start_fetch) begin
        im_rd    <= 1'b1;
        im_addr  <= fetch_addr;
        wait_cnt <= '0;
        br_pend  <= 1'b0;
      end
      if (state == ST_WAIT) begin
        if (im_ack || timeout) begin
          im_rd   <= 1'b0;
          br_pend <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt_inc;
          if (br_taken) begin
            br_pend      <= 1'b1;
            br_pend_addr <= br_addr;
          end
        end
      end
      if (accept) begin
        IR <= im_data;
      end
      if (accept && is_halt(im_data)) begin
        halted <= 1'b1;
      end
      if (timeout) begin
        fault <= 1'b1;
      end
    end
  end

  sisc_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .CLK      (CLK),
    .RST_F    (RST_F),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction fetch sequencer for the sisc processor; produces the IR word the sisc core consumes.
- Owns the program counter. On request from the core's control unit it issues a read to the instruction memory, waits for the memory acknowledge, and returns the 32-bit instruction with a one-cycle valid strobe.
- Handles taken branches, stops on a halt opcode, and flags a memory timeout as a sticky fault.

Parameters:
- ADDR_W, 16, program counter and instruction-memory address width (word addressed).
- RESET_PC, 0, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles spent waiting for im_ack before the fault is raised (1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_F  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  control unit requests the next instruction; sampled only in IDLE.
- br_taken  in  1  branch taken; loads br_addr into the PC.
- br_addr  in  ADDR_W  branch target.
- im_rd  out  1  instruction-memory read strobe, held until ack.
- im_addr  out  ADDR_W  instruction-memory address; stable while im_rd is high.
- im_data  in  32  instruction-memory read data; valid when im_ack is high.
- im_ack  in  1  instruction-memory acknowledge, one-cycle pulse.
- IR  out  32  current instruction register.
- ir_valid  out  1  one-cycle strobe: IR was updated this cycle.
- pc  out  ADDR_W  current program counter.
- halted  out  1  halt opcode fetched; sticky until reset.
- fault  out  1  memory timeout; sticky until reset.

Behaviour:
- Clock and reset: one clock, CLK. RST_F is asynchronous and active-low.
- Reset values: pc=RESET_PC, IR=32'h00000000 (nop), ir_valid=0, im_rd=0, im_addr=0, halted=0, fault=0, wait counter=0, state=IDLE.
- States: IDLE, WAIT, HALT, FAULT.
- IDLE:
  - fetch_req=1 → next cycle im_rd=1 and im_addr=pc, go WAIT.
  - br_taken=1 → pc<=br_addr.
  - fetch_req and br_taken in the same cycle → branch wins the address: im_addr=br_addr, pc<=br_addr.
- WAIT:
  - im_rd stays high. The wait counter increments each cycle in WAIT.
  - im_ack=1 → im_rd<=0, IR<=im_data, ir_valid=1 for exactly one cycle, pc<=pc+1.
  - PC wraps: all-ones + 1 = 0.
  - After ack, if im_data[31:28]==4'hF go HALT and set halted=1; otherwise go IDLE.
  - fetch_req is ignored in WAIT. Each fetch_req accepted in IDLE produces exactly one memory read.
- Branch during WAIT:
  - br_taken=1 sets a pending-branch flag and captures br_addr.
  - When the ack arrives, im_data is discarded: IR is unchanged, no ir_valid. Then pc<=captured br_addr, flag cleared, go IDLE.
  - br_taken in the same cycle as the ack is treated the same way: data discarded, pc<=br_addr.
- Timeout: counter reaches MAX_WAIT without an ack → im_rd<=0, fault=1, go FAULT. The counter clears on each new entry to WAIT.
- HALT and FAULT are terminal: all inputs are ignored, outputs are held, im_rd=0. Only RST_F exits.
- Latency: fetch_req in IDLE at cycle N, im_ack at cycle N+1+k → ir_valid at cycle N+2+k. The minimum fetch is 2 cycles with a zero-wait memory.
- Reset mid-fetch:
  - im_rd drops immediately (asynchronously).
  - Any pending branch is lost.
  - A late im_ack arriving after reset is ignored because the block is in IDLE.
- Memory protocol: one outstanding read at most. An im_ack received while im_rd=0 is ignored.

Decomposition:
- Shared package sisc_pkg:
  - opcode field position [31:28]
  - OP_NOP=4'h0, OP_ALU=4'h8, OP_HALT=4'hF
  - state encoding constants for IDLE/WAIT/HALT/FAULT
  - NOP_WORD=32'h00000000
- One sub-module is natural: sisc_pc_reg, the PC register with load (branch), increment (wrap), and reset-to-RESET_PC. The FSM, IR latch and timeout counter stay in the top module.

Test Plan:
- Reset then idle: RST_F low 20 ns → IR=0, pc=0, im_rd=0, halted=0, fault=0; no reads issued while fetch_req=0.
- Sequential fetch: memory returns 32'h8801000A, 32'h88020007, 32'h80213002 at addresses 0, 1, 2 with 1-cycle ack delay; three fetch_req pulses → IR takes each word in order with one ir_valid each; pc goes 1, 2, 3; im_addr is 0, 1, 2.
- Halt: word 3 = 32'hF0000000 → ir_valid once, halted=1, pc=4; further fetch_req pulses cause no im_rd.
- Branch: br_taken with br_addr=16'h0040 while in WAIT on address 1 → acked data discarded (IR unchanged, no ir_valid), pc=16'h0040; next fetch reads address 0x0040. Also check simultaneous fetch_req+br_taken in IDLE → im_addr=0x0040.
- Timeout and wrap: memory never acks → fault=1 exactly MAX_WAIT cycles after im_rd rises, and im_rd drops. After reset with RESET_PC=16'hFFFF, one fetch → pc=0.
- Reset mid-WAIT: assert RST_F low during WAIT → im_rd=0 immediately; an ack arriving after reset release does not update IR.
